sram_fifo: RTL



---
 rtl/sram_fifo_pkg.sv | 20 ++
 rtl/sram_fifo_if.sv | 34 +++
 rtl/sram_fifo_skid2.sv | 71 +++++++
 rtl/sram_fifo_sram.sv | 48 ++++
 rtl/sram_fifo.sv | 108 ++++++++++
 5 files changed

// File: rtl/sram_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sram_fifo_pkg
//   Shared definitions for the SRAM-backed FIFO slice.
//   - con_rw_e    : read/write collision behaviour of the two-port SRAM model
//   - count_width : occupancy counter width for a given SRAM depth
//                   (SRAM words + one in-flight read + two skid entries)
// -----------------------------------------------------------------------------
package sram_fifo_pkg;

   typedef enum logic [1:0] {
      CON_RW_UNDEF       = 2'd0,
      CON_RW_WRITE_FIRST = 2'd1,
      CON_RW_READ_FIRST  = 2'd2
   } con_rw_e;

   function automatic int count_width(input int ndata);
      return $clog2(ndata + 3);
   endfunction

endpackage

// File: rtl/sram_fifo_if.sv
// -----------------------------------------------------------------------------
// sram_fifo_if
//   Stream bundle around the FIFO: upstream (src) rdy/ack/data, downstream
//   (dst) rdy/ack/data and the occupancy count.
//   slave  : the FIFO side (accepts src, presents dst)
//   master : the environment side (drives src, consumes dst)
// -----------------------------------------------------------------------------
interface sram_fifo_if
   import sram_fifo_pkg::*;
#(
   parameter int BW    = 8,
   parameter int NDATA = 16
);
   localparam int CW = count_width(NDATA);

   logic          src_rdy;
   logic          src_ack;
   logic [BW-1:0] src_data;
   logic          dst_rdy;
   logic          dst_ack;
   logic [BW-1:0] dst_data;
   logic [CW-1:0] count;

   modport slave (
      input  src_rdy, src_data, dst_ack,
      output src_ack, dst_rdy, dst_data, count
   );

   modport master (
      output src_rdy, src_data, dst_ack,
      input  src_ack, dst_rdy, dst_data, count
   );

endinterface

// File: rtl/sram_fifo_skid2.sv
// -----------------------------------------------------------------------------
// fifo_skid2
//   Two-entry output buffer for SRAM-backed stages. Captures read data the
//   cycle it returns from the SRAM and presents the oldest entry at o_head.
//   Ports: i_clk, i_rst (async, active-low); i_load/i_load_data capture;
//          i_pop removes the head; o_cnt entries held (0..2); o_head oldest.
//   The producer must never load into a full buffer unless it also pops.
// -----------------------------------------------------------------------------
module fifo_skid2 #(
   parameter int BW = 8
)
(
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_load,
   input  logic [BW-1:0] i_load_data,
   input  logic          i_pop,
   output logic [1:0]    o_cnt,
   output logic [BW-1:0] o_head
);
   logic [BW-1:0] entry_q [2];
   logic [BW-1:0] entry_d [2];
   logic [1:0]    cnt_q;
   logic [1:0]    cnt_d;
   logic [1:0]    slot;

   always_comb begin
      entry_d[0] = entry_q[0];
      entry_d[1] = entry_q[1];
      cnt_d      = cnt_q + {1'b0, i_load} - {1'b0, i_pop};
      // After an optional shift, the new word lands just behind the survivors.
      slot       = cnt_q - {1'b0, i_pop};
      if (i_pop) begin
         entry_d[0] = entry_q[1];
      end
      if (i_load) begin
         if (slot == 2'd0) begin
            entry_d[0] = i_load_data;
         end else begin
            entry_d[1] = i_load_data;
         end
      end
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge i_clk or negedge i_rst) begin
         if (!i_rst) begin
            entry_q[gi] <= '0;
         end else begin
            entry_q[gi] <= entry_d[gi];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         cnt_q <= 2'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_cnt  = cnt_q;
   assign o_head = entry_q[0];

   cnt_range_a: assert property (@(posedge i_clk) disable iff (!i_rst)
      cnt_q <= 2'd2);
   no_overflow_a: assert property (@(posedge i_clk) disable iff (!i_rst)
      !(i_load && !i_pop && (cnt_q == 2'd2)));

endmodule

// File: rtl/sram_fifo_sram.sv
// -----------------------------------------------------------------------------
// SRAMTwoPort
//   Behavioural model of the two-port SRAM macro: one write port, one read
//   port, registered read data (1-cycle latency).
//   Ports: i_clk; i_we/i_waddr/i_wdata write port; i_re/i_raddr read request;
//          o_rdata valid the cycle after i_re.
//   CON_RW selects what a same-address read returns while that address is
//   being written; UNDEF returns X so any client relying on it shows up.
// -----------------------------------------------------------------------------
module SRAMTwoPort
   import sram_fifo_pkg::*;
#(
   parameter int      BW     = 8,
   parameter int      NDATA  = 16,
   parameter con_rw_e CON_RW = CON_RW_UNDEF
)
(
   input  logic                     i_clk,
   input  logic                     i_we,
   input  logic [$clog2(NDATA)-1:0] i_waddr,
   input  logic [BW-1:0]            i_wdata,
   input  logic                     i_re,
   input  logic [$clog2(NDATA)-1:0] i_raddr,
   output logic [BW-1:0]            o_rdata
);
   logic [BW-1:0] mem [NDATA];
   logic [BW-1:0] rdata_q;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         if (i_we && (i_waddr == i_raddr)) begin
            case (CON_RW)
               CON_RW_WRITE_FIRST: rdata_q <= i_wdata;
               CON_RW_READ_FIRST:  rdata_q <= mem[i_raddr];
               default:            rdata_q <= 'x;
            endcase
         end else begin
            rdata_q <= mem[i_raddr];
         end
      end
   end

   assign o_rdata = rdata_q;

endmodule

// File: rtl/sram_fifo.sv
// -----------------------------------------------------------------------------
// sram_fifo
//   Synchronous FIFO using one two-port SRAM as storage plus a 2-entry output
//   skid that hides the SRAM's registered read latency. Capacity NDATA+2.
//   Ports: i_clk; i_rst (async, active-low);
//          bus (sram_fifo_if.slave): src rdy/ack/data in, dst rdy/ack/data
//          out, count = SRAM words + in-flight read + skid entries.
//   Reads are issued only when the skid is guaranteed room for the returning
//   word, and a read never targets the address being written, so the SRAM's
//   collision behaviour is never exercised.
// -----------------------------------------------------------------------------
module sram_fifo
   import sram_fifo_pkg::*;
#(
   parameter int BW    = 8,
   parameter int NDATA = 16
)
(
   input  logic        i_clk,
   input  logic        i_rst,
   sram_fifo_if.slave  bus
);
   localparam int CLOG2_NDATA = $clog2(NDATA);
   localparam int CW          = count_width(NDATA);

   logic [CLOG2_NDATA-1:0] waddr_q, waddr_d;
   logic [CLOG2_NDATA-1:0] raddr_q, raddr_d;
   logic [CW-1:0]          sram_cnt_q, sram_cnt_d;
   logic [CW-1:0]          count_q, count_d;
   logic                   inflight_q, inflight_d;

   logic                   src_ack;
   logic                   push;
   logic                   pop;
   logic                   issue;
   logic [2:0]             skid_occ;
   logic [1:0]             skid_cnt;
   logic [BW-1:0]          skid_head;
   logic [BW-1:0]          sram_rdata;

   always_comb begin
      // Full only looks at the SRAM; a same-cycle pop does not open a slot.
      src_ack    = (sram_cnt_q < CW'(NDATA));
      push       = bus.src_rdy && src_ack;
      pop        = (skid_cnt != 2'd0) && bus.dst_ack;
      // Skid entries still committed after this edge, counting the read in flight.
      skid_occ   = {1'b0, skid_cnt} + {2'b00, inflight_q} - {2'b00, pop};
      issue      = (sram_cnt_q != '0) && (skid_occ <= 3'd1);

      waddr_d    = push  ? waddr_q + CLOG2_NDATA'(1) : waddr_q;
      raddr_d    = issue ? raddr_q + CLOG2_NDATA'(1) : raddr_q;
      sram_cnt_d = sram_cnt_q + CW'(push) - CW'(issue);
      count_d    = count_q + CW'(push) - CW'(pop);
      inflight_d = issue;
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         waddr_q    <= '0;
         raddr_q    <= '0;
         sram_cnt_q <= '0;
         count_q    <= '0;
         inflight_q <= 1'b0;
      end else begin
         waddr_q    <= waddr_d;
         raddr_q    <= raddr_d;
         sram_cnt_q <= sram_cnt_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
      end
   end

   SRAMTwoPort #(
      .BW     (BW),
      .NDATA  (NDATA),
      .CON_RW (CON_RW_UNDEF)
   ) u_sram (
      .i_clk   (i_clk),
      .i_we    (push),
      .i_waddr (waddr_q),
      .i_wdata (bus.src_data),
      .i_re    (issue),
      .i_raddr (raddr_q),
      .o_rdata (sram_rdata)
   );

   fifo_skid2 #(
      .BW (BW)
   ) u_skid (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_load      (inflight_q),
      .i_load_data (sram_rdata),
      .i_pop       (pop),
      .o_cnt       (skid_cnt),
      .o_head      (skid_head)
   );

   assign bus.src_ack  = src_ack;
   assign bus.dst_rdy  = (skid_cnt != 2'd0);
   assign bus.dst_data = skid_head;
   assign bus.count    = count_q;

   // An issued slot is always occupied and a written slot always free.
   addr_safe_a: assert property (@(posedge i_clk) disable iff (!i_rst)
      !(push && issue && (waddr_q == raddr_q)));

endmodule
